// File: rtl/rf_pkg.sv
// Shared types and helpers for the integer register file.
// Index/word typedefs, zero-register index, packed-port unpacking.
package rf_pkg;

  localparam int ADDR_W   = 5;
  localparam int WORD_W   = 32;
  localparam int MAX_AW   = 8;
  localparam int MAX_READ = 4;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [MAX_READ*MAX_AW-1:0] ra_bus_t;

  localparam reg_idx_t ZERO_IDX = '0;

  // Field i of a packed address bus whose fields are aw bits wide.
  function automatic logic [MAX_AW-1:0] port_idx(
    input ra_bus_t     ra,
    input int unsigned i,
    input int unsigned aw
  );
    logic [MAX_AW-1:0] mask;
    mask = MAX_AW'((1 << aw) - 1);
    return MAX_AW'(ra >> (i * aw)) & mask;
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus of the register file.
// master: RA, WA3, WD3, WEN, ISSUE_EN, ISSUE_RD, FLUSH out; RD, BUSY in.
interface reg_file_sb_if #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_READ      = 2
);

  logic [NUM_READ*ADDRESS_WIDTH-1:0] RA;
  logic [NUM_READ*WORD_WIDTH-1:0]    RD;
  logic [NUM_READ-1:0]               BUSY;
  logic [ADDRESS_WIDTH-1:0]          WA3;
  logic [WORD_WIDTH-1:0]             WD3;
  logic                              WEN;
  logic                              ISSUE_EN;
  logic [ADDRESS_WIDTH-1:0]          ISSUE_RD;
  logic                              FLUSH;

  modport master (
    output RA, WA3, WD3, WEN,
    output ISSUE_EN, ISSUE_RD, FLUSH,
    input  RD, BUSY
  );

  modport slave (
    input  RA, WA3, WD3, WEN,
    input  ISSUE_EN, ISSUE_RD, FLUSH,
    output RD, BUSY
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard with registered BUSY lookup.
// In: ra_i, wa_i, wen_i, issue_en_i, issue_rd_i, flush_i; out: busy_o.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_READ      = 2,
  parameter int ZERO_REG      = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] ra_i,
  input  logic [ADDRESS_WIDTH-1:0]          wa_i,
  input  logic                              wen_i,
  input  logic                              issue_en_i,
  input  logic [ADDRESS_WIDTH-1:0]          issue_rd_i,
  input  logic                              flush_i,
  output logic [NUM_READ-1:0]               busy_o
);

  localparam int DEPTH = 2**ADDRESS_WIDTH;

  typedef logic [ADDRESS_WIDTH-1:0] idx_t;

  logic [DEPTH-1:0]    pend_q, pend_d;
  logic [NUM_READ-1:0] busy_q, busy_d;
  idx_t                ra_idx [NUM_READ];

  // Set beats clear: the issuing instruction is newer than the writer.
  always_comb begin
    pend_d = pend_q;
    for (int r = 0; r < DEPTH; r++) begin
      if (flush_i) begin
        pend_d[r] = 1'b0;
      end else if (issue_en_i &&
                   issue_rd_i == idx_t'(r) &&
                   !(ZERO_REG != 0 && r == 0)) begin
        pend_d[r] = 1'b1;
      end else if (wen_i && wa_i == idx_t'(r)) begin
        pend_d[r] = 1'b0;
      end
    end
  end

  // A write forwarded this cycle also clears its BUSY.
  always_comb begin
    busy_d = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      ra_idx[i] = idx_t'(port_idx(
        ra_bus_t'(ra_i), i, ADDRESS_WIDTH));
      busy_d[i] = !flush_i &&
        !(ZERO_REG != 0 &&
          ra_idx[i] == idx_t'(ZERO_IDX)) &&
        pend_q[ra_idx[i]] &&
        !(wen_i && wa_i == ra_idx[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      busy_q <= '0;
    end else begin
      pend_q <= pend_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read register file with x0, write bypass and hazard scoreboard.
// Ports: clk, rst_n, bus (slave: RA/RD/BUSY, WA3/WD3/WEN, issue, FLUSH).
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_READ      = 2,
  parameter int ZERO_REG      = 1,
  parameter int BYPASS        = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_file_sb_if.slave bus
);

  localparam int DEPTH = 2**ADDRESS_WIDTH;
  localparam int W     = WORD_WIDTH;

  typedef logic [ADDRESS_WIDTH-1:0] idx_t;
  typedef logic [WORD_WIDTH-1:0]    wd_t;

  wd_t                    mem_q [DEPTH];
  logic [NUM_READ*W-1:0]  rd_q, rd_d;
  idx_t                   ra_idx [NUM_READ];
  logic                   wr_en;
  logic                   wa_zero;

  assign wa_zero = bus.WA3 == idx_t'(ZERO_IDX);
  assign wr_en   = bus.WEN &&
                   !(ZERO_REG != 0 && wa_zero);

  // Read mux: x0, then forwarded write, then array.
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      ra_idx[i] = idx_t'(port_idx(
        ra_bus_t'(bus.RA), i, ADDRESS_WIDTH));
      if (ZERO_REG != 0 &&
          ra_idx[i] == idx_t'(ZERO_IDX)) begin
        rd_d[i*W +: W] = '0;
      end else if (BYPASS != 0 && bus.WEN &&
                   bus.WA3 == ra_idx[i]) begin
        rd_d[i*W +: W] = bus.WD3;
      end else begin
        rd_d[i*W +: W] = mem_q[ra_idx[i]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
      rd_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[bus.WA3] <= bus.WD3;
      end
      rd_q <= rd_d;
    end
  end

  assign bus.RD = rd_q;

  rf_scoreboard #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .NUM_READ      (NUM_READ),
    .ZERO_REG      (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .ra_i       (bus.RA),
    .wa_i       (bus.WA3),
    .wen_i      (bus.WEN),
    .issue_en_i (bus.ISSUE_EN),
    .issue_rd_i (bus.ISSUE_RD),
    .flush_i    (bus.FLUSH),
    .busy_o     (bus.BUSY)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: bypass, x0, scoreboard, flush.
// Three builds share stimulus: default, no-bypass, four read ports.
module tb_reg_file_sb;
  import rf_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  logic [19:0] ra = '0;
  reg_idx_t wa = '0;
  word_t    wd = '0;
  logic     wen = 1'b0;
  logic     ien = 1'b0;
  reg_idx_t ird = '0;
  logic     flush = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  reg_file_sb_if #(32, 5, 2) if_a ();
  reg_file_sb_if #(32, 5, 2) if_b ();
  reg_file_sb_if #(32, 5, 4) if_c ();

  assign if_a.RA = ra[9:0];
  assign if_b.RA = ra[9:0];
  assign if_c.RA = ra;
  assign if_a.WA3 = wa;
  assign if_b.WA3 = wa;
  assign if_c.WA3 = wa;
  assign if_a.WD3 = wd;
  assign if_b.WD3 = wd;
  assign if_c.WD3 = wd;
  assign if_a.WEN = wen;
  assign if_b.WEN = wen;
  assign if_c.WEN = wen;
  assign if_a.ISSUE_EN = ien;
  assign if_b.ISSUE_EN = ien;
  assign if_c.ISSUE_EN = ien;
  assign if_a.ISSUE_RD = ird;
  assign if_b.ISSUE_RD = ird;
  assign if_c.ISSUE_RD = ird;
  assign if_a.FLUSH = flush;
  assign if_b.FLUSH = flush;
  assign if_c.FLUSH = flush;

  reg_file_sb #(
    .WORD_WIDTH(32), .ADDRESS_WIDTH(5),
    .NUM_READ(2), .ZERO_REG(1), .BYPASS(1)
  ) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));

  reg_file_sb #(
    .WORD_WIDTH(32), .ADDRESS_WIDTH(5),
    .NUM_READ(2), .ZERO_REG(1), .BYPASS(0)
  ) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  reg_file_sb #(
    .WORD_WIDTH(32), .ADDRESS_WIDTH(5),
    .NUM_READ(4), .ZERO_REG(1), .BYPASS(1)
  ) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] pk(
    input reg_idx_t a0, input reg_idx_t a1,
    input reg_idx_t a2, input reg_idx_t a3
  );
    return {a3, a2, a1, a0};
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    ra = pk(5'd5, 5'd31, 5'd0, 5'd0);
    tick();
    chk("rst_rd0", if_a.RD[31:0], 0);
    chk("rst_rd1", if_a.RD[63:32], 0);
    chk("rst_busy", if_a.BUSY, 0);

    // async reset mid-cycle
    wen = 1; wa = 5; wd = 32'hA5A5;
    tick();
    wen = 0;
    chk("pre_arst_rd0", if_a.RD[31:0], 32'hA5A5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd0", if_a.RD[31:0], 0);
    chk("arst_c_rd", if_c.RD, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("arst_discard", if_a.RD[31:0], 0);

    // write + bypass
    wen = 1; wa = 7; wd = 32'hDEADBEEF;
    ra = pk(5'd7, 5'd31, 5'd0, 5'd0);
    tick();
    wen = 0;
    chk("byp_rd0", if_a.RD[31:0], 32'hDEADBEEF);
    chk("nobyp_rd0", if_b.RD[31:0], 0);
    tick();
    chk("nobyp_rd0_late", if_b.RD[31:0], 32'hDEADBEEF);
    ra = pk(5'd7, 5'd7, 5'd0, 5'd0);
    tick();
    chk("same_addr", if_a.RD, {32'hDEADBEEF, 32'hDEADBEEF});

    // x0
    wen = 1; wa = 0; wd = 32'h12345678;
    ra = pk(5'd0, 5'd7, 5'd0, 5'd0);
    tick();
    wen = 0;
    chk("x0_wr_byp", if_a.RD[31:0], 0);
    tick();
    chk("x0_rd", if_a.RD[31:0], 0);
    ien = 1; ird = 0;
    tick();
    ien = 0;
    tick();
    chk("x0_busy", if_a.BUSY[0], 0);

    // scoreboard hazard
    ra = pk(5'd0, 5'd3, 5'd0, 5'd0);
    ien = 1; ird = 3;
    tick();
    ien = 0;
    chk("iss_same_cyc", if_a.BUSY[1], 0);
    tick();
    chk("iss_busy", if_a.BUSY[1], 1);
    wen = 1; wa = 3; wd = 32'h55;
    tick();
    wen = 0;
    chk("wb_busy_clr", if_a.BUSY[1], 0);
    chk("wb_rd1", if_a.RD[63:32], 32'h55);

    // issue and write same register
    ra = pk(5'd9, 5'd0, 5'd0, 5'd0);
    ien = 1; ird = 9;
    wen = 1; wa = 9; wd = 32'h99;
    tick();
    ien = 0; wen = 0;
    chk("iw_rd0_byp", if_a.RD[31:0], 32'h99);
    chk("iw_busy0_now", if_a.BUSY[0], 0);
    tick();
    chk("iw_rd0", if_a.RD[31:0], 32'h99);
    chk("iw_busy0", if_a.BUSY[0], 1);
    chk("iw_nobyp_rd0", if_b.RD[31:0], 32'h99);

    // flush with four read ports
    wen = 1;
    wa = 4; wd = 32'h44; tick();
    wa = 5; wd = 32'h55; tick();
    wa = 6; wd = 32'h66; tick();
    wen = 0;
    ien = 1;
    ird = 4; tick();
    ird = 5; tick();
    ird = 6; tick();
    ien = 0;
    ra = pk(5'd4, 5'd5, 5'd6, 5'd0);
    tick();
    chk("c_busy_pre", if_c.BUSY, 4'b0111);
    chk("c_rd", if_c.RD,
        {32'h0, 32'h66, 32'h55, 32'h44});
    flush = 1; ien = 1; ird = 4;
    tick();
    flush = 0; ien = 0;
    chk("c_busy_flush", if_c.BUSY, 0);
    tick();
    chk("c_busy_post", if_c.BUSY, 0);
    chk("a_busy_post", if_a.BUSY, 0);

    // stale writeback after flush
    wen = 1; wa = 5; wd = 32'h77;
    tick();
    wen = 0;
    tick();
    chk("stale_rd1", if_a.RD[63:32], 32'h77);
    chk("stale_busy1", if_a.BUSY[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised integer register file for the pipelined RISC-V core. It succeeds the single-write, two-read register file and adds:
- a configurable number of synchronous read ports
- a hardwired-zero register x0
- write-to-read bypass
- asynchronous reset of the whole array
- a per-register pending-write scoreboard that decode uses for hazard stalls

It sits between decode (reads, issue) and writeback (write port).

Parameters:
- WORD_WIDTH, 32, data width of each register
- ADDRESS_WIDTH, 5, register index width; depth = 2**ADDRESS_WIDTH
- NUM_READ, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never marked pending
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read

Ports:
- clk, input, 1, rising-edge clock
- rst_n, input, 1, asynchronous active-low reset
- RA, input, NUM_READ*ADDRESS_WIDTH, packed read addresses; port i = bits [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- RD, output, NUM_READ*WORD_WIDTH, packed registered read data
- BUSY, output, NUM_READ, registered pending flag per read port
- WA3, input, ADDRESS_WIDTH, write address
- WD3, input, WORD_WIDTH, write data
- WEN, input, 1, write enable (writeback)
- ISSUE_EN, input, 1, an instruction with destination ISSUE_RD issues this cycle
- ISSUE_RD, input, ADDRESS_WIDTH, destination of the issuing instruction
- FLUSH, input, 1, pipeline flush; clears all pending bits

Behaviour:
- Reset (rst_n low, asynchronous):
  - every array entry = 0
  - RD = 0, BUSY = 0, all pending bits = 0
  - Deassertion takes effect on the first clk edge after rst_n rises.
  - Reset mid-operation discards any in-flight write.
- Write: at posedge, if WEN and not (ZERO_REG and WA3 == 0), array[WA3] <= WD3.
- Read latency is 1 cycle. At posedge, for each port i, RD_i <= first match in this order:
  - 0, if ZERO_REG and RA_i == 0
  - WD3, if BYPASS and WEN and WA3 == RA_i (write-first)
  - array[RA_i] otherwise (old value when BYPASS = 0)
- Read ports are fully independent; identical addresses on several ports are legal and return identical data.
- Scoreboard update: pending[r] is one flop per register. Next-state priority per register r:
  1. FLUSH -> 0 for all r
  2. ISSUE_EN and ISSUE_RD == r and not (ZERO_REG and r == 0) -> 1
  3. WEN and WA3 == r -> 0
  4. otherwise hold
- Simultaneous issue and writeback to the same register: set wins, because the newer instruction owns the register.
- BUSY readout: at posedge, BUSY_i <= pending[RA_i] and not (WEN and WA3 == RA_i).
  - An issue in the same cycle is not visible until the following read.
  - A write clears BUSY in the same cycle it is forwarded.
  - BUSY_i <= 0 when FLUSH, and when ZERO_REG and RA_i == 0.
- Writeback to a register with pending = 0 (stale or flushed): data is still written, pending stays 0.
- There is no full or empty condition; address wrap is inherent in the ADDRESS_WIDTH truncation.

Decomposition:
- Package rf_pkg:
  - typedef reg_idx_t (ADDRESS_WIDTH bits)
  - typedef word_t (WORD_WIDTH bits)
  - constant ZERO_IDX = 0
  - function for unpacking port i from RA/RD
- One sub-module rf_scoreboard:
  - holds the pending vector, set/clear/flush logic and the BUSY lookup
  - instantiated once
- Data array and read muxes stay in reg_file_sb.

Test Plan:
1. Reset then read: rst_n low for 2 cycles, then RA0 = 5, RA1 = 31 -> RD0 = 0, RD1 = 0, BUSY = 0; pulse rst_n low asynchronously mid-cycle after a write -> RD clears immediately.
2. Write/read and bypass:
   - WEN = 1, WA3 = 7, WD3 = 0xDEADBEEF with RA0 = 7 in the same cycle -> next cycle RD0 = 0xDEADBEEF (BYPASS = 1).
   - With BYPASS = 0 -> RD0 = 0, and 0xDEADBEEF one cycle later.
3. x0: WEN = 1, WA3 = 0, WD3 = 0x12345678, then RA0 = 0 -> RD0 = 0; ISSUE_EN with ISSUE_RD = 0 -> BUSY0 stays 0.
4. Scoreboard hazard:
   - ISSUE_EN, ISSUE_RD = 3 in cycle n; RA1 = 3 in cycle n+1 -> BUSY1 = 1.
   - WEN, WA3 = 3, WD3 = 0x55 with RA1 = 3 -> next cycle BUSY1 = 0, RD1 = 0x55.
5. Simultaneous issue and write to register 9 -> pending[9] = 1 and the data is written; a later read shows BUSY = 1 with RD = the new data.
6. Flush: issue registers 4, 5 and 6, then FLUSH together with ISSUE_RD = 4 -> all BUSY = 0 on subsequent reads of 4, 5 and 6; NUM_READ = 4 build reads 4, 5, 6, 0 in parallel -> all ports correct.
